sfifo_wr_arb: RTL and testbench

Round-robin write arbiter that shares one synchronous FIFO (a `gen_sfifo` instance) among `NUM_REQ` producer ports. It grants one requester at a time, optionally holding the grant for a whole burst. It throttles all producers from the FIFO's almost-full flag and registers the FIFO write port. It sits directly in front of the shared FIFO's `wdata`/`wen` inputs; the FIFO read side is untouched.

---
 rtl/sfifo_wr_arb_if.sv | 34 +++
 rtl/sfifo_wr_arb.sv | 154 +++++++++++++++
 tb/tb_sfifo_wr_arb.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sfifo_wr_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : sfifo_wr_arb_if
// Brief    : Producer-side handshake and shared-FIFO write bus of sfifo_wr_arb.
// Revision : 1.0 - initial release
// ============================================================================
interface sfifo_wr_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_ID   = 2,
    parameter int WIDTH_DATA = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*WIDTH_DATA-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [WIDTH_DATA-1:0]         fifo_wdata;
    logic [WIDTH_ID-1:0]           fifo_wid;
    logic                          fifo_wen;
    logic                          fifo_alfull;
    logic                          fifo_full;

    // master: producers plus FIFO status; slave: the arbiter
    modport master (
        output req_valid, req_data, req_last, fifo_alfull, fifo_full,
        input  req_ready, fifo_wdata, fifo_wid, fifo_wen
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_alfull, fifo_full,
        output req_ready, fifo_wdata, fifo_wid, fifo_wen
    );
endinterface

`default_nettype wire

// File: rtl/sfifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : sfifo_wr_arb
// Brief    : Round-robin write arbiter sharing one sync FIFO among NUM_REQ
//            producers. Define SFIFO_WR_ARB_LOCK_EN to hold grants per burst.
// Revision : 1.0 - initial release
// ============================================================================
module sfifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_ID   = 2,
    parameter int WIDTH_DATA = 32,
    parameter int MAX_BURST  = 64
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    sfifo_wr_arb_if.slave       bus,
    output logic [WIDTH_ID-1:0] grant_id,
    output logic                busy,
    output logic                err_ovf,
    output logic                err_burst
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0]       c_ST_IDLE   = 1'b0;
    localparam logic [0:0]       c_ST_BUSY   = 1'b1;
    localparam logic [CNT_W-1:0] c_MAX_BURST = CNT_W'(MAX_BURST);

    logic [0:0]            r_state;
    logic [WIDTH_ID-1:0]   r_grant;
    logic [WIDTH_ID-1:0]   r_last_grant;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic [WIDTH_DATA-1:0] r_wdata;
    logic [WIDTH_ID-1:0]   r_wid;
    logic                  r_wen;
    logic                  r_err_ovf;
    logic                  r_err_burst;

    logic [WIDTH_ID-1:0]   w_pick;
    int                    w_best;
    int                    w_dist;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_sel_valid;
    logic [WIDTH_DATA-1:0] w_sel_data;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_cnt_hit;
    logic                  w_release;
    logic                  w_burst_err;

    // Round-robin: smallest upward distance from last_grant+1 wins
    always_comb begin
        w_pick = '0;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ;
            if (bus.req_valid[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_pick = WIDTH_ID'(i);
            end
        end
    end

    // Granted-port mux; ready never looks at req_valid
    always_comb begin
        w_ready     = '0;
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (WIDTH_ID'(i) == r_grant) begin
                w_sel_valid = bus.req_valid[i];
                w_sel_data  = bus.req_data[i*WIDTH_DATA +: WIDTH_DATA];
                w_ready[i]  = (r_state == c_ST_BUSY) && !bus.fifo_alfull;
            end
        end
    end

    assign w_accept  = (r_state == c_ST_BUSY) && !bus.fifo_alfull && w_sel_valid;
    assign w_cnt_nxt = r_beat_cnt + 1'b1;
    assign w_cnt_hit = (w_cnt_nxt == c_MAX_BURST);

`ifdef SFIFO_WR_ARB_LOCK_EN
    logic w_sel_last;

    always_comb begin
        w_sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (WIDTH_ID'(i) == r_grant) begin
                w_sel_last = bus.req_last[i];
            end
        end
    end

    assign w_release   = w_accept && (w_sel_last || w_cnt_hit);
    assign w_burst_err = w_accept && w_cnt_hit && !w_sel_last;
`else
    // Per-beat grants; the count only reaches MAX_BURST when MAX_BURST is 1
    assign w_release   = w_accept;
    assign w_burst_err = w_accept && w_cnt_hit;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= WIDTH_ID'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
            r_wdata      <= '0;
            r_wid        <= '0;
            r_wen        <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_burst  <= 1'b0;
        end else begin
            r_wen <= w_accept;
            if (w_accept) begin
                r_wdata <= w_sel_data;
                r_wid   <= r_grant;
            end
            if (r_wen && bus.fifo_full) begin
                r_err_ovf <= 1'b1;
            end
            if (w_burst_err) begin
                r_err_burst <= 1'b1;
            end
            if (r_state == c_ST_IDLE) begin
                if (|bus.req_valid) begin
                    r_grant    <= w_pick;
                    r_beat_cnt <= '0;
                    r_state    <= c_ST_BUSY;
                end
            end else if (w_accept) begin
                r_beat_cnt <= w_cnt_nxt;
                if (w_release) begin
                    r_state      <= c_ST_IDLE;
                    r_last_grant <= r_grant;
                end
            end
        end
    end

    // A registered beat meeting a full FIFO is dropped rather than written
    assign bus.fifo_wen   = r_wen && !bus.fifo_full;
    assign bus.fifo_wdata = r_wdata;
    assign bus.fifo_wid   = r_wid;
    assign bus.req_ready  = w_ready;

    assign grant_id  = r_grant;
    assign busy      = (r_state == c_ST_BUSY);
    assign err_ovf   = r_err_ovf;
    assign err_burst = r_err_burst;

endmodule

`default_nettype wire

// File: tb/tb_sfifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfifo_wr_arb
// Brief    : Cycle-table and scoreboard bench for sfifo_wr_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfifo_wr_arb;
    localparam int NUM_REQ    = 4;
    localparam int WIDTH_ID   = 2;
    localparam int WIDTH_DATA = 32;
    localparam int MAX_BURST  = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [WIDTH_ID-1:0] grant_id;
    logic                busy;
    logic                err_ovf;
    logic                err_burst;

    sfifo_wr_arb_if #(.NUM_REQ(NUM_REQ), .WIDTH_ID(WIDTH_ID), .WIDTH_DATA(WIDTH_DATA)) bus ();

    sfifo_wr_arb #(
        .NUM_REQ(NUM_REQ), .WIDTH_ID(WIDTH_ID), .WIDTH_DATA(WIDTH_DATA), .MAX_BURST(MAX_BURST)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus),
        .grant_id(grant_id), .busy(busy), .err_ovf(err_ovf), .err_burst(err_burst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid; logic [3:0] last; logic alfull; logic full; logic drop;
        logic [3:0] ready; logic wen; logic bsy; logic [1:0] grant; logic ovf; logic burst;
    } vec_t;

    typedef struct {
        logic [WIDTH_ID-1:0]   wid;
        logic [WIDTH_DATA-1:0] data;
    } beat_t;

    vec_t  tbl[$];
    beat_t sb[$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    cyc     = 0;

    function automatic vec_t mk(int va, int la, int af, int fu, int dr,
                                int rd, int we, int bz, int gr, int ov, int bu);
        vec_t v;
        v.valid = 4'(va); v.last = 4'(la); v.alfull = 1'(af); v.full = 1'(fu); v.drop = 1'(dr);
        v.ready = 4'(rd); v.wen = 1'(we); v.bsy = 1'(bz); v.grant = 2'(gr);
        v.ovf = 1'(ov); v.burst = 1'(bu);
        return v;
    endfunction

    function automatic logic [31:0] data_of(int c, int i);
        return 32'(c * 256 + i);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply(vec_t v);
        beat_t b;
        @(negedge clk);
        cyc++;
        bus.req_valid   = v.valid;
        bus.req_last    = v.last;
        bus.fifo_alfull = v.alfull;
        bus.fifo_full   = v.full;
        for (int i = 0; i < NUM_REQ; i++)
            bus.req_data[i*WIDTH_DATA +: WIDTH_DATA] = data_of(cyc, i);
        #1;
        check($sformatf("ready@%0d", cyc), 32'(bus.req_ready), 32'(v.ready));
        check($sformatf("wen@%0d", cyc),   32'(bus.fifo_wen),  32'(v.wen));
        check($sformatf("busy@%0d", cyc),  32'(busy),          32'(v.bsy));
        check($sformatf("grant@%0d", cyc), 32'(grant_id),      32'(v.grant));
        check($sformatf("ovf@%0d", cyc),   32'(err_ovf),       32'(v.ovf));
        check($sformatf("burst@%0d", cyc), 32'(err_burst),     32'(v.burst));
        if (v.drop || bus.fifo_wen) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_empty@%0d: got write/drop expected none", cyc);
            end else begin
                b = sb.pop_front();
                if (!v.drop) begin
                    check($sformatf("wid@%0d", cyc),   32'(bus.fifo_wid), 32'(b.wid));
                    check($sformatf("wdata@%0d", cyc), bus.fifo_wdata,    b.data);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++)
            if (v.ready[i] && v.valid[i])
                sb.push_back('{wid: WIDTH_ID'(i), data: data_of(cyc, i)});
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
        check({tag, "_wen"},   32'(bus.fifo_wen),  32'h0);
        check({tag, "_wdata"}, bus.fifo_wdata,     32'h0);
        check({tag, "_wid"},   32'(bus.fifo_wid),  32'h0);
        check({tag, "_busy"},  32'(busy),          32'h0);
        check({tag, "_grant"}, 32'(grant_id),      32'h0);
        check({tag, "_ovf"},   32'(err_ovf),       32'h0);
        check({tag, "_burst"}, 32'(err_burst),     32'h0);
    endtask

    initial begin
        logic [1:0] g_end;
        logic       b_end;
        rst_n           = 1'b0;
        bus.req_valid   = '0;
        bus.req_last    = '0;
        bus.req_data    = '0;
        bus.fifo_alfull = 1'b0;
        bus.fifo_full   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Per-beat round robin, skip patterns, alfull stall, grant stall, overflow
        tbl.push_back(mk('b1111,'b1111,0,0,0, 'b0000,0,0,0,0,0));
        tbl.push_back(mk('b1111,'b1111,0,0,0, 'b0001,0,1,0,0,0));
        tbl.push_back(mk('b1111,'b1111,0,0,0, 'b0000,1,0,0,0,0));
        tbl.push_back(mk('b1111,'b1111,0,0,0, 'b0010,0,1,1,0,0));
        tbl.push_back(mk('b1111,'b1111,0,0,0, 'b0000,1,0,1,0,0));
        tbl.push_back(mk('b1111,'b1111,0,0,0, 'b0100,0,1,2,0,0));
        tbl.push_back(mk('b1111,'b1111,0,0,0, 'b0000,1,0,2,0,0));
        tbl.push_back(mk('b1111,'b1111,0,0,0, 'b1000,0,1,3,0,0));
        tbl.push_back(mk('b1111,'b1111,0,0,0, 'b0000,1,0,3,0,0));
        tbl.push_back(mk('b1111,'b1111,0,0,0, 'b0001,0,1,0,0,0));
        tbl.push_back(mk('b0101,'b1111,0,0,0, 'b0000,1,0,0,0,0));
        tbl.push_back(mk('b0101,'b1111,0,0,0, 'b0100,0,1,2,0,0));
        tbl.push_back(mk('b0101,'b1111,0,0,0, 'b0000,1,0,2,0,0));
        tbl.push_back(mk('b0101,'b1111,0,0,0, 'b0001,0,1,0,0,0));
        tbl.push_back(mk('b1000,'b1111,0,0,0, 'b0000,1,0,0,0,0));
        tbl.push_back(mk('b1000,'b1111,1,0,0, 'b0000,0,1,3,0,0));
        tbl.push_back(mk('b1000,'b1111,1,0,0, 'b0000,0,1,3,0,0));
        tbl.push_back(mk('b1000,'b1111,1,0,0, 'b0000,0,1,3,0,0));
        tbl.push_back(mk('b1000,'b1111,0,0,0, 'b1000,0,1,3,0,0));
        tbl.push_back(mk('b0010,'b1111,0,0,0, 'b0000,1,0,3,0,0));
        tbl.push_back(mk('b0000,'b1111,0,0,0, 'b0010,0,1,1,0,0));
        tbl.push_back(mk('b0001,'b1111,0,0,0, 'b0010,0,1,1,0,0));
        tbl.push_back(mk('b0010,'b1111,0,0,0, 'b0010,0,1,1,0,0));
        tbl.push_back(mk('b0000,'b1111,0,1,1, 'b0000,0,0,1,0,0));
        tbl.push_back(mk('b0000,'b1111,0,0,0, 'b0000,0,0,1,1,0));
        tbl.push_back(mk('b0001,'b1111,0,0,0, 'b0000,0,0,1,1,0));
        tbl.push_back(mk('b0001,'b1111,0,0,0, 'b0001,0,1,0,1,0));
        tbl.push_back(mk('b0000,'b1111,0,0,0, 'b0000,1,0,0,1,0));
        g_end = 2'd0;
        b_end = 1'b0;
`ifdef SFIFO_WR_ARB_LOCK_EN
        // Requester 2 holds a 5-beat burst over requester 1, then requester 1
        // streams without req_last, stalls on alfull, and is force-released
        tbl.push_back(mk('b0100,'b0000,0,0,0, 'b0000,0,0,0,1,0));
        tbl.push_back(mk('b0110,'b0000,0,0,0, 'b0100,0,1,2,1,0));
        tbl.push_back(mk('b0110,'b0000,0,0,0, 'b0100,1,1,2,1,0));
        tbl.push_back(mk('b0110,'b0000,0,0,0, 'b0100,1,1,2,1,0));
        tbl.push_back(mk('b0110,'b0000,0,0,0, 'b0100,1,1,2,1,0));
        tbl.push_back(mk('b0110,'b0100,0,0,0, 'b0100,1,1,2,1,0));
        tbl.push_back(mk('b0010,'b0000,0,0,0, 'b0000,1,0,2,1,0));
        tbl.push_back(mk('b0010,'b0000,0,0,0, 'b0010,0,1,1,1,0));
        tbl.push_back(mk('b0010,'b0000,0,0,0, 'b0010,1,1,1,1,0));
        tbl.push_back(mk('b0010,'b0000,1,0,0, 'b0000,1,1,1,1,0));
        tbl.push_back(mk('b0010,'b0000,1,0,0, 'b0000,0,1,1,1,0));
        tbl.push_back(mk('b0010,'b0000,1,0,0, 'b0000,0,1,1,1,0));
        tbl.push_back(mk('b0010,'b0000,0,0,0, 'b0010,0,1,1,1,0));
        tbl.push_back(mk('b0010,'b0000,0,0,0, 'b0010,1,1,1,1,0));
        tbl.push_back(mk('b0010,'b0000,0,0,0, 'b0010,1,1,1,1,0));
        tbl.push_back(mk('b0000,'b0000,0,0,0, 'b0000,1,0,1,1,1));
        tbl.push_back(mk('b0000,'b0000,0,0,0, 'b0000,0,0,1,1,1));
        g_end = 2'd1;
        b_end = 1'b1;
`endif
        foreach (tbl[k]) apply(tbl[k]);

        // Asynchronous reset while a beat is registered but not yet written
        apply(mk('b0100,'b0000,0,0,0, 'b0000,0,0,g_end,1,b_end));
        apply(mk('b0100,'b0000,0,0,0, 'b0100,0,1,2,1,b_end));
        @(posedge clk);
        #1;
        check("wen_before_rst", 32'(bus.fifo_wen), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb.delete();
        @(negedge clk);
        bus.req_valid = '0;
        rst_n         = 1'b1;
        apply(mk('b1111,'b1111,0,0,0, 'b0000,0,0,0,0,0));
        apply(mk('b1111,'b1111,0,0,0, 'b0001,0,1,0,0,0));
        apply(mk('b0000,'b1111,0,0,0, 'b0000,1,0,0,0,0));
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
